// File: rtl/ray_column_scan_pkg.sv
// Shared definitions for the ray column scanner: FSM states and fixed-point constants.
package ray_column_scan_pkg;

   // Width of every signed Q8.8 coordinate, offset and distance
   localparam int Q_W = 16;

   // Distance reported for a column whose ray hits no wall
   localparam logic [Q_W-1:0] MISS_DIST = 16'h7FFF;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DIR_REQ  = 3'd1,
      DIR_CAP  = 3'd2,
      WALL_REQ = 3'd3,
      WALL_CAP = 3'd4,
      CAST     = 3'd5,
      EMIT     = 3'd6,
      FINISH   = 3'd7
   } state_t;

endpackage

// File: rtl/ray_column_scan.sv
// Frame scanner: for each screen column, casts one ray against every wall via an
// external combinational caster, keeps the nearest hit, and hands the result out
// over a valid/ready handshake.
module ray_column_scan
   import ray_column_scan_pkg::*;
#(
   parameter int NUM_COLS = 160,
   parameter int WALL_AW  = 6,
   parameter int COL_AW   = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [Q_W-1:0]     player_x,
   input  logic [Q_W-1:0]     player_y,
   input  logic [WALL_AW:0]   num_walls,
   output logic [COL_AW-1:0]  dir_addr,
   input  logic [Q_W-1:0]     dir_dx,
   input  logic [Q_W-1:0]     dir_dy,
   output logic [WALL_AW-1:0] wall_addr,
   input  logic [Q_W-1:0]     wall_x3,
   input  logic [Q_W-1:0]     wall_y3,
   input  logic [Q_W-1:0]     wall_x4,
   input  logic [Q_W-1:0]     wall_y4,
   output logic [Q_W-1:0]     rc_x1,
   output logic [Q_W-1:0]     rc_y1,
   output logic [Q_W-1:0]     rc_x2,
   output logic [Q_W-1:0]     rc_y2,
   output logic [Q_W-1:0]     rc_x3,
   output logic [Q_W-1:0]     rc_y3,
   output logic [Q_W-1:0]     rc_x4,
   output logic [Q_W-1:0]     rc_y4,
   input  logic               rc_hit,
   input  logic [Q_W-1:0]     rc_dist,
   input  logic [Q_W-1:0]     rc_uv,
   output logic               col_valid,
   input  logic               col_ready,
   output logic [COL_AW-1:0]  col_idx,
   output logic               col_hit,
   output logic [Q_W-1:0]     col_dist,
   output logic [Q_W-1:0]     col_uv,
   output logic [WALL_AW-1:0] col_wall,
   output logic               busy,
   output logic               done
);

   localparam logic [WALL_AW:0]  MAX_WALLS = (WALL_AW+1)'(1) << WALL_AW;
   localparam logic [COL_AW-1:0] LAST_COL  = COL_AW'(NUM_COLS - 1);

   state_t               state, state_next;
   logic [COL_AW-1:0]    column;
   logic [WALL_AW-1:0]   wall;
   logic [WALL_AW:0]     wall_count;
   logic [Q_W-1:0]       origin_x, origin_y;
   logic [Q_W-1:0]       best_dist, best_uv;
   logic [WALL_AW-1:0]   best_wall;
   logic                 best_hit;
   logic                 more_walls;
   logic                 last_col;

   // Widened so wall+1 cannot wrap when the clamped count is 2^WALL_AW
   assign more_walls = ({1'b0, wall} + (WALL_AW+1)'(1)) < wall_count;
   assign last_col   = (column == LAST_COL);

   // Memory addresses come straight from the loop counters; the memories register the read
   assign dir_addr  = column;
   assign wall_addr = wall;

   // Handshake and status outputs decode the registered state only
   assign col_valid = (state == EMIT);
   assign busy      = (state != IDLE) && (state != FINISH);
   assign done      = (state == FINISH);
   assign col_idx   = column;
   assign col_hit   = best_hit;
   assign col_dist  = best_dist;
   assign col_uv    = best_uv;
   assign col_wall  = best_wall;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (start) state_next = DIR_REQ;
         DIR_REQ:  state_next = DIR_CAP;
         DIR_CAP:  state_next = (wall_count == '0) ? EMIT : WALL_REQ;
         WALL_REQ: state_next = WALL_CAP;
         WALL_CAP: state_next = CAST;
         CAST:     state_next = more_walls ? WALL_REQ : EMIT;
         EMIT:     if (col_ready) state_next = last_col ? FINISH : DIR_REQ;
         FINISH:   state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Frame inputs, loop counters, caster operands and nearest-hit tracking
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         column     <= '0;
         wall       <= '0;
         wall_count <= '0;
         origin_x   <= '0;
         origin_y   <= '0;
         best_dist  <= '0;
         best_uv    <= '0;
         best_wall  <= '0;
         best_hit   <= 1'b0;
         rc_x1      <= '0;
         rc_y1      <= '0;
         rc_x2      <= '0;
         rc_y2      <= '0;
         rc_x3      <= '0;
         rc_y3      <= '0;
         rc_x4      <= '0;
         rc_y4      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  column     <= '0;
                  origin_x   <= player_x;
                  origin_y   <= player_y;
                  wall_count <= (num_walls > MAX_WALLS) ? MAX_WALLS : num_walls;
               end
            end
            DIR_CAP: begin
               rc_x1     <= origin_x;
               rc_y1     <= origin_y;
               rc_x2     <= origin_x + dir_dx;
               rc_y2     <= origin_y + dir_dy;
               best_dist <= MISS_DIST;
               best_uv   <= '0;
               best_wall <= '0;
               best_hit  <= 1'b0;
               wall      <= '0;
            end
            WALL_CAP: begin
               rc_x3 <= wall_x3;
               rc_y3 <= wall_y3;
               rc_x4 <= wall_x4;
               rc_y4 <= wall_y4;
            end
            CAST: begin
               // Strict compare: on a tie the earlier (lower-index) wall stays
               if (rc_hit && (rc_dist < best_dist)) begin
                  best_dist <= rc_dist;
                  best_uv   <= rc_uv;
                  best_wall <= wall;
                  best_hit  <= 1'b1;
               end
               if (more_walls) wall <= wall + WALL_AW'(1);
            end
            EMIT: begin
               if (col_ready && !last_col) column <= column + COL_AW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ray_column_scan.sv
// Directed bench for ray_column_scan with a vertical-wall model caster and
// registered-read direction/wall memories.
module tb_ray_column_scan;
   import ray_column_scan_pkg::*;

   localparam int NUM_COLS = 8;
   localparam int WALL_AW  = 6;
   localparam int COL_AW   = 8;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               start;
   logic [15:0]        player_x, player_y;
   logic [WALL_AW:0]   num_walls;
   logic [COL_AW-1:0]  dir_addr;
   logic [15:0]        dir_dx, dir_dy;
   logic [WALL_AW-1:0] wall_addr;
   logic [15:0]        wall_x3, wall_y3, wall_x4, wall_y4;
   logic [15:0]        rc_x1, rc_y1, rc_x2, rc_y2, rc_x3, rc_y3, rc_x4, rc_y4;
   logic               rc_hit;
   logic [15:0]        rc_dist, rc_uv;
   logic               col_valid, col_ready;
   logic [COL_AW-1:0]  col_idx;
   logic               col_hit;
   logic [15:0]        col_dist, col_uv;
   logic [WALL_AW-1:0] col_wall;
   logic               busy, done;

   logic [15:0] mem_x3 [64];
   logic [15:0] mem_y3 [64];
   logic [15:0] mem_x4 [64];
   logic [15:0] mem_y4 [64];

   int passed = 0;
   int failed = 0;
   int total  = 0;

   ray_column_scan #(.NUM_COLS(NUM_COLS), .WALL_AW(WALL_AW), .COL_AW(COL_AW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .player_x(player_x), .player_y(player_y), .num_walls(num_walls),
      .dir_addr(dir_addr), .dir_dx(dir_dx), .dir_dy(dir_dy),
      .wall_addr(wall_addr), .wall_x3(wall_x3), .wall_y3(wall_y3),
      .wall_x4(wall_x4), .wall_y4(wall_y4),
      .rc_x1(rc_x1), .rc_y1(rc_y1), .rc_x2(rc_x2), .rc_y2(rc_y2),
      .rc_x3(rc_x3), .rc_y3(rc_y3), .rc_x4(rc_x4), .rc_y4(rc_y4),
      .rc_hit(rc_hit), .rc_dist(rc_dist), .rc_uv(rc_uv),
      .col_valid(col_valid), .col_ready(col_ready), .col_idx(col_idx),
      .col_hit(col_hit), .col_dist(col_dist), .col_uv(col_uv), .col_wall(col_wall),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Direction table: every column looks along +x by 1.0
   always @(posedge clk) begin
      dir_dx <= (dir_addr < COL_AW'(NUM_COLS)) ? 16'h0100 : 16'h0000;
      dir_dy <= 16'h0000;
   end

   // Wall memory with registered read
   always @(posedge clk) begin
      wall_x3 <= mem_x3[wall_addr];
      wall_y3 <= mem_y3[wall_addr];
      wall_x4 <= mem_x4[wall_addr];
      wall_y4 <= mem_y4[wall_addr];
   end

   // Model caster: vertical walls ahead of a +x ray; distance is the x gap
   always_comb begin
      rc_hit  = ($signed(rc_x2) > $signed(rc_x1)) && (rc_x3 == rc_x4) &&
                ($signed(rc_x3) > $signed(rc_x1)) &&
                ($signed(rc_y1) >= $signed(rc_y3)) && ($signed(rc_y1) <= $signed(rc_y4));
      rc_dist = rc_x3 - rc_x1;
      rc_uv   = rc_y1 - rc_y3;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_wall(input int i, input logic [15:0] x, input logic [15:0] ylo,
                           input logic [15:0] yhi);
      mem_x3[i] = x;
      mem_x4[i] = x;
      mem_y3[i] = ylo;
      mem_y4[i] = yhi;
   endtask

   // One frame; checks every transfer, optional stall and mid-frame start/input poke
   task automatic run_frame(input logic e_hit, input logic [15:0] e_dist,
                            input logic [15:0] e_uv, input logic [WALL_AW-1:0] e_wall,
                            input int stall_col, input int poke_col, input int bound);
      int next_idx = 0;
      int stall = 0;
      int dones = 0;
      int cycles = 0;
      bit poked = 0;
      logic [63:0] snap = '0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", {63'd0, busy}, 64'd1);
      while (next_idx < NUM_COLS && cycles < bound) begin
         start = 1'b0;
         if (done) dones++;
         col_ready = 1'b1;
         if (col_valid) begin
            if (int'(col_idx) == stall_col && stall < 10) begin
               col_ready = 1'b0;
               if (stall == 0)
                  snap = {17'd0, col_idx, col_hit, col_dist, col_uv, col_wall};
               else
                  chk("stall_stable", {17'd0, col_idx, col_hit, col_dist, col_uv, col_wall}, snap);
               stall++;
            end else begin
               chk("col_idx",  64'(col_idx),  64'(next_idx));
               chk("col_hit",  64'(col_hit),  64'(e_hit));
               chk("col_dist", 64'(col_dist), 64'(e_dist));
               chk("col_uv",   64'(col_uv),   64'(e_uv));
               chk("col_wall", 64'(col_wall), 64'(e_wall));
               next_idx++;
            end
         end
         if (poke_col >= 0 && !poked && next_idx == poke_col) begin
            poked     = 1;
            start     = 1'b1;
            player_x  = 16'h0100;
            num_walls = '0;
         end
         @(negedge clk);
         cycles++;
      end
      start = 1'b0;
      chk("frame_in_budget", 64'(cycles < bound), 64'd1);
      if (stall_col >= 0) chk("stall_cycles", 64'(stall), 64'd10);
      chk("done_after_last", {63'd0, done}, 64'd1);
      chk("busy_at_finish",  {63'd0, busy}, 64'd0);
      for (int i = 0; i < 4; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      chk("done_pulses", 64'(dones), 64'd1);
      chk("idle_busy", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int waited;
      reset_n   = 1'b0;
      start     = 1'b0;
      col_ready = 1'b1;
      player_x  = '0;
      player_y  = '0;
      num_walls = 7'd1;
      for (int i = 0; i < 64; i++) set_wall(i, 16'h0300, 16'hFF00, 16'h0100);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_busy",      {63'd0, busy}, 64'd0);
      chk("rst_col_valid", {63'd0, col_valid}, 64'd0);
      chk("rst_done",      {63'd0, done}, 64'd0);
      chk("rst_addrs",     64'({dir_addr, wall_addr}), 64'd0);
      chk("rst_rc",        64'({rc_x2, rc_y2, rc_x3}), 64'd0);

      // Single wall at x=2.0; stall column 5; pulse start and change inputs mid-frame
      set_wall(0, 16'h0200, 16'hFF00, 16'h0100);
      num_walls = 7'd1;
      run_frame(1'b1, 16'h0200, 16'h0100, 6'd0, 5, 2, 400);
      player_x = '0;

      // Two walls, farther one first: nearest is wall 1
      set_wall(0, 16'h0300, 16'hFF00, 16'h0100);
      set_wall(1, 16'h0200, 16'hFF00, 16'h0100);
      num_walls = 7'd2;
      run_frame(1'b1, 16'h0200, 16'h0100, 6'd1, -1, -1, 400);

      // Two walls at equal distance: lower index wins
      set_wall(0, 16'h0200, 16'hFF00, 16'h0100);
      run_frame(1'b1, 16'h0200, 16'h0100, 6'd0, -1, -1, 400);

      // No walls: every column misses
      num_walls = 7'd0;
      run_frame(1'b0, 16'h7FFF, 16'h0000, 6'd0, -1, -1, 400);

      // Oversized count clamps to 64; the nearest wall is the last one
      for (int i = 0; i < 64; i++) set_wall(i, 16'h0300, 16'hFF00, 16'h0100);
      set_wall(63, 16'h0100, 16'hFF00, 16'h0100);
      num_walls = 7'd100;
      run_frame(1'b1, 16'h0100, 16'h0100, 6'd63, -1, -1, 3000);

      // Reset during CAST of column 3, with start held in the same cycle
      set_wall(0, 16'h0200, 16'hFF00, 16'h0100);
      num_walls = 7'd1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waited = 0;
      while (!(dut.state == CAST && dut.column == 3) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      chk("reach_cast_col3", 64'(waited < 200), 64'd1);
      reset_n = 1'b0;
      start   = 1'b1;
      @(negedge clk);
      chk("midrst_busy",      {63'd0, busy}, 64'd0);
      chk("midrst_col_valid", {63'd0, col_valid}, 64'd0);
      chk("midrst_outs",      64'({col_idx, col_dist, wall_addr, rc_x2}), 64'd0);
      reset_n = 1'b1;
      start   = 1'b0;
      repeat (3) @(negedge clk);
      chk("start_in_reset_ignored", {63'd0, busy}, 64'd0);
      run_frame(1'b1, 16'h0200, 16'h0100, 6'd0, -1, -1, 400);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ray_column_scan.md
RAY_COLUMN_SCAN -- requirements
Module: ray_column_scan

Interface
REQ-001 Parameter NUM_COLS, default 160, screen columns per frame scan.
REQ-002 Parameter WALL_AW, default 6, wall-memory address width (max 64 walls).
REQ-003 Parameter COL_AW, default 8, column index width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a frame scan when idle.
REQ-007 player_x, player_y  in  16 each  signed Q8.8 ray origin, sampled at accepted start.
REQ-008 num_walls  in  WALL_AW+1  wall count, sampled at accepted start.
REQ-009 dir_addr  out  COL_AW  direction-table read address.
REQ-010 dir_dx, dir_dy  in  16 each  signed Q8.8 ray offset, valid one cycle after dir_addr.
REQ-011 wall_addr  out  WALL_AW  wall-memory read address.
REQ-012 wall_x3, wall_y3, wall_x4, wall_y4  in  16 each  signed Q8.8 wall endpoints, valid one cycle after wall_addr.
REQ-013 rc_x1..rc_y4  out  16 each  registered operands to the combinational ray-wall caster.
REQ-014 rc_hit  in  1; rc_dist  in  16; rc_uv  in  16  caster results, same cycle as operands.
REQ-015 col_valid  out  1; col_ready  in  1  column-result handshake.
REQ-016 col_idx  out  COL_AW; col_hit  out  1; col_dist  out  16; col_uv  out  16; col_wall  out  WALL_AW  column result.
REQ-017 busy  out  1  high from accepted start until frame complete.
REQ-018 done  out  1  one-cycle pulse after last column handshake.

Function
REQ-019 FSM states: IDLE, DIR_REQ, DIR_CAP, WALL_REQ, WALL_CAP, CAST, EMIT, FINISH.
REQ-020 IDLE: start=1 -> DIR_REQ, column=0, busy=1; start while busy ignored.
REQ-021 DIR_REQ: dir_addr=column; next DIR_CAP.
REQ-022 DIR_CAP: rc_x1=player_x, rc_y1=player_y, rc_x2=player_x+dir_dx, rc_y2=player_y+dir_dy (16-bit wrap); best_dist=16'h7FFF, best_hit=0, wall=0; next WALL_REQ, or EMIT if num_walls=0.
REQ-023 WALL_REQ: wall_addr=wall; next WALL_CAP.
REQ-024 WALL_CAP: register wall endpoints into rc_x3..rc_y4; next CAST.
REQ-025 CAST: if rc_hit=1 and rc_dist (unsigned) strictly less than best_dist, latch best_dist, best_uv, best_wall, best_hit=1; equal distances keep lower wall index.
REQ-026 CAST: wall+1 < num_walls -> wall+1, WALL_REQ; else EMIT. Cost: 3 cycles per wall plus 2 per column overhead plus handshake.
REQ-027 EMIT: col_valid=1 with col_idx=column, col_hit=best_hit, col_dist=best_dist, col_uv=best_uv (0 if no hit), col_wall=best_wall (0 if no hit); all held stable until col_ready=1.
REQ-028 Transfer when col_valid and col_ready both high; col_valid drops next cycle; col_valid never depends combinationally on col_ready.
REQ-029 After transfer: column=NUM_COLS-1 -> FINISH; else column+1, DIR_REQ.
REQ-030 FINISH: done=1 one cycle, busy=0, -> IDLE.
REQ-031 player_x, player_y, num_walls changes during busy have no effect on current frame.
REQ-032 num_walls above 2^WALL_AW is clamped to 2^WALL_AW.

Reset
REQ-033 reset_n=0 at a clock edge -> IDLE, all outputs 0, column/wall/best registers 0, including mid-scan and mid-handshake.
REQ-034 start asserted in the same cycle as reset_n=0 is ignored.

Structure
REQ-035 Shared package holds FSM state enum, MISS_DIST constant 16'h7FFF, Q8.8 width constant 16.
REQ-036 No sub-module; the caster is external and wired to rc_* ports by the parent.

Verification
REQ-037 num_walls=1, wall (2.0,-1.0)-(2.0,1.0), origin 0,0, all dirs (1.0,0), model caster -> each column hit=1, dist=0x0200, wall=0.
REQ-038 num_walls=2, walls at x=3.0 and x=2.0 -> best_wall=1, dist=0x0200; equal distances at both -> wall=0.
REQ-039 num_walls=0 -> NUM_COLS results, hit=0, dist=0x7FFF, uv=0, done after last transfer.
REQ-040 col_ready held low 10 cycles on column 5 -> outputs stable, no column skipped or duplicated, col_idx 0..NUM_COLS-1 in order.
REQ-041 reset_n low during CAST of column 3 -> next cycle busy=0, col_valid=0; fresh start rescans from column 0.
REQ-042 start pulsed while busy -> ignored; exactly one done pulse per accepted start.
